bus_arbiter: RTL
================

Name: bus_arbiter

Overview:
- Two-master arbiter and sequencer for the shared system bus that feeds the address decoder and read-data mux.
- Master 0 is the CPU; master 1 is a DMA-class requester (level copier / blitter).
- Arbitrates requests round-robin with an optional lock, then drives the shared address/data/write/strobe for a fixed number of wait cycles.
- Returns registered read data to the winning master with a one-cycle ack.

Parameters:
- WAIT_CYCLES, 1, cycles bus_strobe is held per transaction (legal 1..15).
- LOCK_ENABLE, 1, when 0 the lock inputs are ignored.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- req  input  2  per-master request, held until ack
- lock  input  2  per-master lock: keep ownership across back-to-back transactions
- m0_address  input  30  master 0 word address [31:2]
- m0_data_out  input  32  master 0 write data
- m0_write  input  1  master 0 write (1) / read (0)
- m1_address  input  30  master 1 word address [31:2]
- m1_data_out  input  32  master 1 write data
- m1_write  input  1  master 1 write / read
- bus_data_in  input  32  read data from the data-in mux
- bus_address  output  30  shared address to the decoder
- bus_data_out  output  32  shared write data
- bus_write  output  1  shared write enable
- bus_strobe  output  1  transaction active
- grant  output  2  one-hot owner during ACCESS, 0 otherwise
- ack  output  2  one-cycle completion pulse to the owner
- read_data  output  32  captured bus_data_in, valid with ack

Behaviour:
- Reset values (synchronous, checked at posedge clock): state=IDLE, bus_address=0, bus_data_out=0, bus_write=0, bus_strobe=0, grant=0, ack=0, read_data=0, last_owner=1 (so master 0 wins the first tie), lock_owner=none.
- Reset asserted mid-ACCESS: the next edge forces the reset values. No ack is issued and the aborted transaction is lost.

IDLE:
- ack returns to 0.
- If lock_owner is set and lock[lock_owner]=1:
  - only that master may be chosen; the other master waits even if it is requesting.
  - if the locked master is not requesting, nothing is chosen and the bus stays idle.
- If lock[lock_owner]=0, lock_owner clears this same cycle and normal arbitration applies.
- Normal arbitration:
  - a single requester wins;
  - if both request, the master that is not last_owner wins.
- On choosing master n, register the following and go to ACCESS:
  - bus_address, bus_data_out and bus_write from master n;
  - bus_strobe=1, grant=one-hot(n);
  - counter=WAIT_CYCLES-1;
  - last_owner=n;
  - lock_owner=n if lock[n] and LOCK_ENABLE, else none.
- When no master is chosen: strobe=0, write=0, grant=0. bus_address and bus_data_out hold their last values.

ACCESS:
- Outputs are held stable.
- Master inputs and req changes are ignored: once granted, a transaction always completes.
- If counter != 0, decrement it.
- If counter == 0, at the same edge:
  - read_data <= bus_data_in;
  - ack[n] <= 1;
  - bus_strobe <= 0, bus_write <= 0, grant <= 0;
  - go to IDLE.

Timing:
- Request sampled at edge E0 gives strobe high for edges E1..E_WAIT_CYCLES.
- ack and read_data are visible after edge E_WAIT_CYCLES (i.e. during cycle WAIT_CYCLES+1).
- Minimum period is WAIT_CYCLES+1 cycles per transaction, because the IDLE arbitration cycle always costs one cycle.

Handshake rules:
- A master must drop req in the cycle ack is high, or hold it to request again. The IDLE cycle that follows ack re-arbitrates with req as sampled in that cycle.
- A req dropped before it is granted is simply not serviced.
- read_data is only meaningful on reads; on writes it captures whatever the mux drives.

Test Plan:
- Reset, then master 0 only, read at address 0x0000_0040 with bus_data_in=0xDEADBEEF, WAIT_CYCLES=1 -> strobe high for exactly 1 cycle; grant=01; ack=01 next cycle with read_data=0xDEADBEEF; bus_write=0.
- Both masters request from reset, both held -> grants in the order m0, m1, m0, m1. Each ack is a single-cycle pulse to the right master, and no cycle has two grant bits set.
- Master 1 holds lock=1 and issues 3 writes while master 0 requests throughout -> the 3 writes go to m1 with bus_write=1 and bus_data_out matching. m0 is granted only after m1 drops lock.
- WAIT_CYCLES=3; master 1 drops req 1 cycle after grant -> strobe is still high for 3 cycles, ack[1] still pulses, and the bus returns to IDLE.
- Reset asserted in the second strobe cycle of a WAIT_CYCLES=3 access -> next edge strobe=0, grant=0, ack=0, no ack pulse follows, and master 0 wins the next tie.
- Master 0 requests one cycle before ack to master 1 completes -> m0 is granted in the IDLE cycle immediately after m1's ack, with no extra idle cycles.

Source files
------------

// File: rtl/bus_arbiter.sv
// bus_arbiter
//
// Two-master arbiter and sequencer for the shared system bus. Master 0 is the
// CPU, master 1 is a DMA-class requester. Requests are arbitrated round-robin
// with an optional ownership lock. The winner's address, write data and write
// flag are registered onto the shared bus, and bus_strobe is held for
// WAIT_CYCLES cycles. At the end, the read data is captured and a one-cycle ack
// is returned to the owner.
//
// Handshake: a master raises req[n] and holds it, together with its address,
// data and write flag, until it sees ack[n] high for one cycle. It drops req[n]
// in that ack cycle, or keeps it high to queue another transaction. The IDLE
// cycle that follows an ack re-arbitrates using req as sampled in that cycle.
// Once a master is granted, its transaction always runs to completion.
//
// Parameters:
//   WAIT_CYCLES  cycles bus_strobe is held per transaction (1..15)
//   LOCK_ENABLE  0 = lock inputs ignored
//
// Ports:
//   clock, reset            system clock, synchronous active-high reset
//   req[1:0], lock[1:0]     per-master request / keep-ownership lock
//   m0_*, m1_*              per-master word address, write data, write flag
//   bus_data_in             read data from the data-in mux
//   bus_address/data_out    shared address / write data to the decoder
//   bus_write, bus_strobe   shared write enable / transaction active
//   grant[1:0]              one-hot owner during ACCESS
//   ack[1:0]                one-cycle completion pulse to the owner
//   read_data               captured bus_data_in, valid with ack
//   state_dbg               FSM state: 0 = IDLE, 1 = ACCESS
module bus_arbiter #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter bit          LOCK_ENABLE = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [1:0]  lock,
    input  logic [29:0] m0_address,
    input  logic [31:0] m0_data_out,
    input  logic        m0_write,
    input  logic [29:0] m1_address,
    input  logic [31:0] m1_data_out,
    input  logic        m1_write,
    input  logic [31:0] bus_data_in,
    output logic [29:0] bus_address,
    output logic [31:0] bus_data_out,
    output logic        bus_write,
    output logic        bus_strobe,
    output logic [1:0]  grant,
    output logic [1:0]  ack,
    output logic [31:0] read_data,
    output logic        state_dbg
);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [29:0] bus_address_q, bus_address_d;
    logic [31:0] bus_data_out_q, bus_data_out_d;
    logic        bus_write_q, bus_write_d;
    logic        bus_strobe_q, bus_strobe_d;
    logic [1:0]  grant_q, grant_d;
    logic [1:0]  ack_q, ack_d;
    logic [31:0] read_data_q, read_data_d;
    logic [3:0]  counter_q, counter_d;
    logic        last_owner_q, last_owner_d;
    logic        lock_valid_q, lock_valid_d;
    logic        lock_id_q, lock_id_d;

    logic        lock_hold;
    logic        pick_valid;
    logic        pick_id;

    // The lock only restricts arbitration while its owner keeps lock asserted.
    assign lock_hold = LOCK_ENABLE && lock_valid_q && lock[lock_id_q];

    always_comb begin
        pick_valid = 1'b0;
        pick_id    = 1'b0;
        if (lock_hold) begin
            // The locked master is the only candidate. If it is not
            // requesting, the bus stays idle even when the other master is.
            pick_valid = req[lock_id_q];
            pick_id    = lock_id_q;
        end else begin
            unique case (req)
                2'b01:   begin pick_valid = 1'b1; pick_id = 1'b0;          end
                2'b10:   begin pick_valid = 1'b1; pick_id = 1'b1;          end
                2'b11:   begin pick_valid = 1'b1; pick_id = ~last_owner_q; end
                default: begin pick_valid = 1'b0; pick_id = 1'b0;          end
            endcase
        end
    end

    always_comb begin
        state_d        = state_q;
        bus_address_d  = bus_address_q;
        bus_data_out_d = bus_data_out_q;
        bus_write_d    = bus_write_q;
        bus_strobe_d   = bus_strobe_q;
        grant_d        = grant_q;
        ack_d          = 2'b00;
        read_data_d    = read_data_q;
        counter_d      = counter_q;
        last_owner_d   = last_owner_q;
        lock_valid_d   = lock_valid_q;
        lock_id_d      = lock_id_q;

        unique case (state_q)
            S_IDLE: begin
                if (!lock_hold) begin
                    lock_valid_d = 1'b0;
                end
                if (pick_valid) begin
                    bus_address_d  = pick_id ? m1_address  : m0_address;
                    bus_data_out_d = pick_id ? m1_data_out : m0_data_out;
                    bus_write_d    = pick_id ? m1_write    : m0_write;
                    bus_strobe_d   = 1'b1;
                    grant_d        = pick_id ? 2'b10 : 2'b01;
                    counter_d      = CNT_INIT;
                    last_owner_d   = pick_id;
                    lock_valid_d   = LOCK_ENABLE && lock[pick_id];
                    lock_id_d      = pick_id;
                    state_d        = S_ACCESS;
                end else begin
                    // Address and write data keep their last values.
                    bus_write_d  = 1'b0;
                    bus_strobe_d = 1'b0;
                    grant_d      = 2'b00;
                end
            end

            S_ACCESS: begin
                if (counter_q != 4'd0) begin
                    counter_d = counter_q - 4'd1;
                end else begin
                    read_data_d  = bus_data_in;
                    ack_d        = last_owner_q ? 2'b10 : 2'b01;
                    bus_write_d  = 1'b0;
                    bus_strobe_d = 1'b0;
                    grant_d      = 2'b00;
                    state_d      = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= S_IDLE;
            bus_address_q  <= '0;
            bus_data_out_q <= '0;
            bus_write_q    <= 1'b0;
            bus_strobe_q   <= 1'b0;
            grant_q        <= 2'b00;
            ack_q          <= 2'b00;
            read_data_q    <= '0;
            counter_q      <= 4'd0;
            last_owner_q   <= 1'b1;   // master 0 wins the first tie
            lock_valid_q   <= 1'b0;
            lock_id_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            bus_address_q  <= bus_address_d;
            bus_data_out_q <= bus_data_out_d;
            bus_write_q    <= bus_write_d;
            bus_strobe_q   <= bus_strobe_d;
            grant_q        <= grant_d;
            ack_q          <= ack_d;
            read_data_q    <= read_data_d;
            counter_q      <= counter_d;
            last_owner_q   <= last_owner_d;
            lock_valid_q   <= lock_valid_d;
            lock_id_q      <= lock_id_d;
        end
    end

    assign bus_address  = bus_address_q;
    assign bus_data_out = bus_data_out_q;
    assign bus_write    = bus_write_q;
    assign bus_strobe   = bus_strobe_q;
    assign grant        = grant_q;
    assign ack          = ack_q;
    assign read_data    = read_data_q;
    assign state_dbg    = (state_q == S_ACCESS);

endmodule
